// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// The producer/consumer side takes the master modport; the serializer takes the slave modport.
interface piso_shift_tx_if #(
    parameter int MSB = 8
);
    localparam int CW = $clog2(MSB);

    logic           load_valid;
    logic [MSB-1:0] load_data;
    logic           load_dir;
    logic           load_ready;
    logic           en;
    logic           sdo;
    logic           sdo_valid;
    logic           sdo_last;
    logic           busy;
    logic [CW-1:0]  bit_cnt;

    modport master (
        output load_valid, load_data, load_dir, en,
        input  load_ready, sdo, sdo_valid, sdo_last, busy, bit_cnt
    );

    modport slave (
        input  load_valid, load_data, load_dir, en,
        output load_ready, sdo, sdo_valid, sdo_last, busy, bit_cnt
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word, then emits it one bit per enabled
// cycle in a per-word selectable order, with back-to-back reload on the last bit.
module piso_shift_tx #(
    parameter int MSB = 8
) (
    input  logic             clk,
    input  logic             rstn,
    piso_shift_tx_if.slave   bus
);
    localparam int            CW   = $clog2(MSB);
    localparam logic [CW-1:0] LAST = CW'(MSB - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [MSB-1:0] shreg_q, shreg_d;
    logic           dir_q, dir_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_shift;
    logic           is_last;
    logic           load_ready;
    logic           accept;

    function automatic logic [MSB-1:0] shift_one(input logic [MSB-1:0] v,
                                                 input logic           msb_first);
        return msb_first ? {v[MSB-2:0], 1'b0} : {1'b0, v[MSB-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_shift = (state_q == SHIFT);
        is_last  = in_shift && (cnt_q == LAST);
        // Gated by rstn so ready is low for the whole reset window, not just after an edge.
        load_ready = rstn && (!in_shift || (bus.en && is_last));
        accept     = bus.load_valid && load_ready;

        state_d = state_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = bus.load_data;
                    dir_d   = bus.load_dir;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (accept) begin
                        shreg_d = bus.load_data;
                        dir_d   = bus.load_dir;
                        cnt_d   = '0;
                    end else if (is_last) begin
                        state_d = IDLE;
                        shreg_d = shift_one(shreg_q, dir_q);
                        cnt_d   = '0;
                    end else begin
                        shreg_d = shift_one(shreg_q, dir_q);
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.sdo        = in_shift ? (dir_q ? shreg_q[MSB-1] : shreg_q[0]) : 1'b0;
    assign bus.sdo_valid  = in_shift;
    assign bus.busy       = in_shift;
    assign bus.sdo_last   = is_last;
    assign bus.bit_cnt    = cnt_q;
endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter: MSB, default 8, word width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 load_valid  input  1  a parallel word is offered on load_data.
REQ-005 load_data  input  MSB  parallel word to serialize.
REQ-006 load_dir  input  1  bit order for the offered word: 1 = MSB first (left shift), 0 = LSB first (right shift).
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 en  input  1  shift enable; 0 stalls the serial stream.
REQ-009 sdo  output  1  serial data bit.
REQ-010 sdo_valid  output  1  sdo carries a word bit.
REQ-011 sdo_last  output  1  current sdo bit is the final bit of its word.
REQ-012 busy  output  1  a word is being serialized.
REQ-013 bit_cnt  output  $clog2(MSB)  index of the current bit within the word (0 = first bit sent).

Function
REQ-014 The block SHALL implement two states, IDLE and SHIFT, held in a state register.
REQ-015 A word SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; other cycles SHALL leave the shift register unchanged by load_data.
REQ-016 On acceptance the block SHALL capture load_data into the shift register and load_dir into a per-word direction register, clear bit_cnt to 0, and enter SHIFT.
REQ-017 load_ready SHALL be 1 in IDLE, and in SHIFT only when en=1 and bit_cnt=MSB-1 (back-to-back acceptance); otherwise 0.
REQ-018 In SHIFT, sdo SHALL be shreg[MSB-1] when the latched direction is 1 and shreg[0] when it is 0; in IDLE, sdo SHALL be 0.
REQ-019 sdo_valid and busy SHALL be 1 exactly when state is SHIFT.
REQ-020 sdo_last SHALL be 1 exactly when state is SHIFT and bit_cnt=MSB-1.
REQ-021 A bit SHALL be consumed on each rising edge in SHIFT with en=1: shift register shifts one position in the latched direction, vacated position filled with 0, bit_cnt increments by 1.
REQ-022 With en=0 in SHIFT, shift register, bit_cnt, direction and state SHALL hold; sdo SHALL remain stable.
REQ-023 On consumption of the last bit (bit_cnt=MSB-1, en=1): if a word is accepted the same edge, REQ-016 applies and state stays SHIFT; otherwise state returns to IDLE and bit_cnt to 0.
REQ-024 Latency: first bit of an accepted word SHALL appear on sdo in the cycle after acceptance; a word SHALL occupy exactly MSB enabled cycles, with no idle gap between back-to-back words.
REQ-025 load_dir changes while in SHIFT SHALL NOT affect the word in flight.
REQ-026 en has no effect in IDLE; acceptance in IDLE SHALL NOT depend on en.

Reset
REQ-027 While rstn=0, regardless of clk: state=IDLE, shift register=0, direction register=0, bit_cnt=0, sdo=0, sdo_valid=0, sdo_last=0, busy=0, load_ready=0.
REQ-028 Reset asserted mid-word SHALL discard the word; after rstn deasserts the block SHALL be in IDLE with load_ready=1 and no partial word resumed.

Verification
REQ-029 MSB=8, load 8'hA5 with load_dir=1, en=1 continuously -> sdo sequence 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after acceptance; sdo_last only on the 8th bit; busy falls next cycle.
REQ-030 Load 8'hA5 with load_dir=0 -> sdo sequence 1,0,1,0,0,1,0,1 (LSB first); bit_cnt 0..7.
REQ-031 Back-to-back: load_valid held with 8'hFF then 8'h00 -> 16 consecutive valid bits (eight 1s, then eight 0s), load_ready=1 on the last-bit cycle of the first word, sdo_valid never deasserts.
REQ-032 Stall: load 8'h81 (MSB first), drop en for 3 cycles after bit 2 -> sdo, bit_cnt held at 2 for those cycles; full stream 1,0,0,0,0,0,0,1 delivered; load_ready=0 throughout the stall.
REQ-033 Reset mid-word: assert rstn=0 asynchronously after bit 4 of 8'h3C -> all outputs 0 immediately without a clock edge; after release, load_ready=1, next load 8'hC3 serializes cleanly.
REQ-034 load_dir toggled during SHIFT and load_valid pulsed while load_ready=0 -> in-flight word order unchanged; offered word not accepted.
